cic_rx_sched: RTL and testbench
===============================

// Module: cic_rx_sched
// PURPOSE
//   Sequencer and output scheduler for a bank of NUM_RX CIC decimators.
//   - On a sample-rate change, gates the decimator input strobes, flushes, applies the new rate and discards settling samples.
//   - Merges the per-receiver decimated outputs onto one valid/ready stream, round-robin, for the downstream FIR/FIFO.
// PARAMETERS
//   NUM_RX     4   number of receivers (CIC instances), 1..8
//   DATA_W     24  width of each CIC out_data sample
//   FLUSH_CYC  16  clocks cic_run is held low during a rate change, >=2
//   SETTLE     3   post-restart decimated outputs discarded per channel (= CIC STAGES)
// PORTS
//   clock        in   1              system clock, all logic rising-edge
//   reset        in   1              asynchronous, active-high
//   rate_sel     in   2              requested rate code from host (0=48k,1=96k,2=192k,3=384k)
//   cic_rate     out  2              rate code applied to CIC bank; changes only while cic_run=0
//   cic_run      out  1              ANDed with every CIC in_strobe; 0 = decimators frozen
//   rx_strobe    in   NUM_RX         per-channel CIC out_strobe, 1-cycle pulses
//   rx_data      in   NUM_RX*DATA_W  per-channel CIC out_data, ch k at [k*DATA_W +: DATA_W]
//   m_valid      out  1              output sample valid
//   m_ready      in   1              downstream accept
//   m_data       out  DATA_W         output sample
//   m_chan       out  $clog2(NUM_RX) channel index of m_data (1 bit minimum)
//   overrun      out  NUM_RX         sticky: hold slot overwritten before being sent
//   overrun_clr  in   1              synchronous clear of overrun (and counters)
// BEHAVIOUR
//   - Reset values: cic_run=0, cic_rate=0, m_valid=0, m_data=0, m_chan=0, overrun=0, all hold slots empty, state=FLUSH with counter=FLUSH_CYC-1, RR pointer=0.
//   - FSM FLUSH:
//     - cic_run=0; cic_rate<=rate_sel every cycle.
//     - Counter decrements to 0, then -> SETTLE.
//     - A rate_sel change while in FLUSH reloads the counter.
//   - FSM SETTLE:
//     - cic_run=1; counts rx_strobe[0] pulses (channels run in lockstep); rx_strobe is ignored for capture.
//     - After SETTLE pulses -> RUN.
//     - rate_sel!=cic_rate -> FLUSH.
//   - FSM RUN:
//     - cic_run=1; captures strobes.
//     - rate_sel!=cic_rate -> FLUSH next cycle.
//   - Entering FLUSH (any state): all hold slots cleared. A pending m_valid beat is NOT dropped; it stays until accepted.
//   - Capture: rx_strobe[k] in RUN at cycle N -> slot k full at N+1.
//     - If slot k is already full and not granted in cycle N: data overwritten and overrun[k]<=1.
//     - Grant and capture on the same slot in the same cycle: old value sent, new value stored, no overrun.
//   - Arbiter: the output register loads when (!m_valid | m_ready). Grant goes to the first full slot at or after the RR pointer; the pointer then moves to grant+1 mod NUM_RX.
//   - Latency: strobe at N -> m_valid earliest at N+2.
//   - While m_valid & !m_ready, m_data and m_chan are held stable.
//   - m_valid drops after acceptance if no slot is full. Full-throughput back-to-back beats are required when slots are full.
//   - overrun_clr clears overrun; a set on the same cycle wins.
//   - Reset asserted mid-operation returns all state to reset values immediately (async).
//   - No arithmetic on samples; data passes bit-exact.
// CONFIGURATION
//   - OVERRUN_CNT_EN defined: adds port overrun_cnt out NUM_RX*8, one 8-bit saturating counter per channel.
//     - Increments on each overrun event and saturates at 255.
//     - Cleared by overrun_clr; a same-cycle event loads 1.
//   - OVERRUN_CNT_EN undefined: port and counters absent; only the sticky overrun bits exist.
// STRUCTURE
//   - Package cic_rx_pkg:
//     - state enum {ST_FLUSH, ST_SETTLE, ST_RUN};
//     - rate code constants RATE_48K..RATE_384K;
//     - chan index width function clog2_min1().
//   - Sub-module rr_arbiter: NUM_RX request vector + pointer -> one-hot grant, grant index, any_grant. Purely combinational; the pointer register lives in cic_rx_sched.
// TESTING
//   - Reset release, rate_sel=0 -> cic_run rises exactly FLUSH_CYC clocks later; first 3 ch0 strobes produce no m_valid; the 4th produces m_valid 2 clocks later with m_chan=0.
//   - RUN, m_ready=1, all 4 rx_strobe together with data 0x10,0x11,0x12,0x13 -> four consecutive beats, m_chan 0,1,2,3, matching data, no overrun.
//   - m_ready=0 for 40 clocks, ch2 strobed twice (0xA, then 0xB) -> overrun[2]=1; after m_ready=1 exactly one ch2 beat, with data 0xB.
//   - rate_sel 0->2 while m_valid=1 & m_ready=0 -> pending beat held stable until accepted; cic_run=0 for 16 clocks; cic_rate=2 before cic_run rises; strobes during FLUSH/SETTLE are not emitted.
//   - overrun_clr on the same cycle as a new ch1 overrun -> overrun[1] stays 1. With OVERRUN_CNT_EN, 300 ch1 overruns -> counter=255; after clear -> 0.
//   - Async reset mid-burst (m_valid=1) -> m_valid, cic_run and overrun go to 0 without a clock edge.

Source files
------------

// File: rtl/cic_rx_pkg.sv
// Shared types and helpers for the CIC receive sequencer/scheduler.
package cic_rx_pkg;

    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_SETTLE,
        ST_RUN
    } state_t;

    localparam logic [1:0] RATE_48K  = 2'd0;
    localparam logic [1:0] RATE_96K  = 2'd1;
    localparam logic [1:0] RATE_192K = 2'd2;
    localparam logic [1:0] RATE_384K = 2'd3;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cic_rx_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr.
module rr_arbiter
    import cic_rx_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [CW-1:0] idx,
    output logic          any_grant
);

    logic [CW-1:0] cand;

    always_comb begin
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = CW'((int'(ptr) + i) % N);
            if (!any_grant && req[cand]) begin
                any_grant   = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/cic_rx_sched.sv
// Rate-change sequencer and round-robin output merger for a CIC bank.
// Optional OVERRUN_CNT_EN adds per-channel 8-bit saturating overrun counters.
module cic_rx_sched
    import cic_rx_pkg::*;
#(
    parameter int NUM_RX    = 4,
    parameter int DATA_W    = 24,
    parameter int FLUSH_CYC = 16,
    parameter int SETTLE    = 3,
    localparam int CW       = clog2_min1(NUM_RX)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [1:0]               rate_sel,
    output logic [1:0]               cic_rate,
    output logic                     cic_run,
    input  logic [NUM_RX-1:0]        rx_strobe,
    input  logic [NUM_RX*DATA_W-1:0] rx_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic [CW-1:0]            m_chan,
    output logic [NUM_RX-1:0]        overrun,
`ifdef OVERRUN_CNT_EN
    output logic [NUM_RX*8-1:0]      overrun_cnt,
`endif
    input  logic                     overrun_clr
);

    localparam int FW = clog2_min1(FLUSH_CYC);
    localparam int SW = clog2_min1(SETTLE + 1);

    state_t              state;
    logic [FW-1:0]       fcnt;
    logic [SW-1:0]       scnt;
    logic [NUM_RX-1:0]   full;
    logic [DATA_W-1:0]   slot [NUM_RX];
    logic [CW-1:0]       ptr;
    logic [NUM_RX-1:0]   grant;
    logic [NUM_RX-1:0]   take;
    logic [NUM_RX-1:0]   cap;
    logic [NUM_RX-1:0]   ov_evt;
    logic [CW-1:0]       gidx;
    logic                any_grant;
    logic                load;
    logic                rate_chg;
    logic                go_flush;

    assign rate_chg = (rate_sel != cic_rate);
    assign go_flush = (state != ST_FLUSH) && rate_chg;
    assign load     = !m_valid || m_ready;
    assign take     = load ? grant : '0;
    assign cap      = (state == ST_RUN && !go_flush) ? rx_strobe : '0;
    assign ov_evt   = cap & full & ~take;

    rr_arbiter #(.N(NUM_RX), .CW(CW)) u_arb (
        .req       (full),
        .ptr       (ptr),
        .grant     (grant),
        .idx       (gidx),
        .any_grant (any_grant)
    );

    // New rate is applied on the same edge that freezes the decimators.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_FLUSH;
            fcnt     <= FW'(FLUSH_CYC - 1);
            scnt     <= '0;
            cic_run  <= 1'b0;
            cic_rate <= RATE_48K;
        end else if (go_flush) begin
            state    <= ST_FLUSH;
            fcnt     <= FW'(FLUSH_CYC - 1);
            cic_run  <= 1'b0;
            cic_rate <= rate_sel;
        end else begin
            unique case (state)
                ST_FLUSH: begin
                    cic_rate <= rate_sel;
                    if (rate_chg) begin
                        fcnt <= FW'(FLUSH_CYC - 1);
                    end else if (fcnt == '0) begin
                        state   <= ST_SETTLE;
                        scnt    <= '0;
                        cic_run <= 1'b1;
                    end else begin
                        fcnt <= fcnt - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (rx_strobe[0]) begin
                        if (scnt == SW'(SETTLE - 1)) state <= ST_RUN;
                        else scnt <= scnt + 1'b1;
                    end
                end
                ST_RUN: ;
                default: state <= ST_FLUSH;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full    <= '0;
            ptr     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_chan  <= '0;
            overrun <= '0;
        end else begin
            if (load) begin
                m_valid <= any_grant;
                if (any_grant) begin
                    m_data <= slot[gidx];
                    m_chan <= gidx;
                    ptr    <= (gidx == CW'(NUM_RX - 1)) ? '0 : gidx + 1'b1;
                end
            end
            if (go_flush) full <= '0;
            else full <= (full & ~take) | cap;
            overrun <= (overrun_clr ? '0 : overrun) | ov_evt;
        end
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_RX; k++) begin
            if (cap[k]) slot[k] <= rx_data[k*DATA_W +: DATA_W];
        end
    end

`ifdef OVERRUN_CNT_EN
    logic [7:0] ocnt [NUM_RX];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_RX; k++) ocnt[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_RX; k++) begin
                if (overrun_clr) ocnt[k] <= {7'd0, ov_evt[k]};
                else if (ov_evt[k] && ocnt[k] != 8'hFF) ocnt[k] <= ocnt[k] + 8'd1;
            end
        end
    end

    always_comb begin
        overrun_cnt = '0;
        for (int k = 0; k < NUM_RX; k++) overrun_cnt[k*8 +: 8] = ocnt[k];
    end
`endif

endmodule

// File: tb/tb_cic_rx_sched.sv
// Self-checking bench for cic_rx_sched (NUM_RX=4, DATA_W=24, FLUSH_CYC=16, SETTLE=3).
module tb_cic_rx_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  rate_sel;
    logic [1:0]  cic_rate;
    logic        cic_run;
    logic [3:0]  rx_strobe;
    logic [95:0] rx_data;
    logic        m_valid;
    logic        m_ready;
    logic [23:0] m_data;
    logic [1:0]  m_chan;
    logic [3:0]  overrun;
    logic        overrun_clr;
`ifdef OVERRUN_CNT_EN
    logic [31:0] overrun_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    cic_rx_sched #(
        .NUM_RX(4), .DATA_W(24), .FLUSH_CYC(16), .SETTLE(3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rate_sel    (rate_sel),
        .cic_rate    (cic_rate),
        .cic_run     (cic_run),
        .rx_strobe   (rx_strobe),
        .rx_data     (rx_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_chan      (m_chan),
        .overrun     (overrun),
`ifdef OVERRUN_CNT_EN
        .overrun_cnt (overrun_cnt),
`endif
        .overrun_clr (overrun_clr)
    );

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic strobe(input logic [3:0] m, input logic [23:0] base);
        rx_strobe = m;
        for (int k = 0; k < 4; k++) rx_data[k*24 +: 24] = base + 24'(k);
        tick();
        rx_strobe = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rate_sel = 2'd0; rx_strobe = '0; rx_data = '0;
        m_ready = 1'b1; overrun_clr = 1'b0;
        tick(); tick();
        checks++;
        if ({cic_run, cic_rate, m_valid, m_data, m_chan, overrun} !== 34'd0) begin
            errors++;
            $display("FAIL reset_state: got run=%b rate=%0d v=%b d=%h ch=%0d ov=%b want all zero",
                     cic_run, cic_rate, m_valid, m_data, m_chan, overrun);
        end
    endtask

    task automatic test_flush_settle();
        int n = 0;
        reset = 1'b0;
        do begin tick(); n++; end while (!cic_run && n < 100);
        checks++;
        if (n != 16) begin
            errors++; $display("FAIL flush_len: got %0d want 16", n);
        end
        for (int s = 0; s < 3; s++) begin
            strobe(4'hF, 24'h20);
            tick(); tick();
            checks++;
            if (m_valid !== 1'b0) begin
                errors++; $display("FAIL settle_drop%0d: got m_valid=%b want 0", s, m_valid);
            end
        end
        strobe(4'hF, 24'h20);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL first_lat1: got m_valid=%b want 0", m_valid);
        end
        for (int k = 0; k < 4; k++) begin
            if (k > 0 || 1) tick();
            checks++;
            if ({m_valid, m_chan, m_data} !== {1'b1, 2'(k), 24'h20 + 24'(k)}) begin
                errors++;
                $display("FAIL first_beat%0d: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                         k, m_valid, m_chan, m_data, k, 24'h20 + 24'(k));
            end
        end
        tick();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL first_drain: got m_valid=%b want 0", m_valid);
        end
    endtask

    task automatic test_burst();
        strobe(4'hF, 24'h10);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({m_valid, m_chan, m_data} !== {1'b1, 2'(k), 24'h10 + 24'(k)}) begin
                errors++;
                $display("FAIL burst_beat%0d: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                         k, m_valid, m_chan, m_data, k, 24'h10 + 24'(k));
            end
        end
        tick();
        checks++;
        if ({m_valid, overrun} !== 5'd0) begin
            errors++; $display("FAIL burst_end: got v=%b ov=%b want 0 0000", m_valid, overrun);
        end
    endtask

    task automatic test_overrun();
        int nb = 0;
        int n2 = 0;
        logic [23:0] d2 = '0;
        m_ready = 1'b0;
        strobe(4'h1, 24'h55);
        tick();
        strobe(4'h4, 24'hA - 24'd2);
        tick(); tick();
        strobe(4'h4, 24'hB - 24'd2);
        repeat (34) tick();
        checks++;
        if ({overrun, m_valid, m_chan, m_data} !== {4'b0100, 1'b1, 2'd0, 24'h55}) begin
            errors++;
            $display("FAIL overrun_set: got ov=%b v=%b ch=%0d d=%h want ov=0100 v=1 ch=0 d=000055",
                     overrun, m_valid, m_chan, m_data);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (m_valid) begin
                nb++;
                if (m_chan == 2'd2) begin n2++; d2 = m_data; end
            end
            tick();
        end
        checks++;
        if (nb != 2 || n2 != 1 || d2 !== 24'hB) begin
            errors++;
            $display("FAIL overrun_drain: got beats=%0d ch2=%0d d=%h want 2 1 00000b", nb, n2, d2);
        end
    endtask

    task automatic test_overrun_clr();
        m_ready = 1'b0;
        strobe(4'h8, 24'h33 - 24'd3);
        tick();
        strobe(4'h2, 24'h0);
        tick();
        overrun_clr = 1'b1;
        strobe(4'h2, 24'h1);
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 4'b0010) begin
            errors++; $display("FAIL clr_vs_set: got ov=%b want 0010", overrun);
        end
`ifdef OVERRUN_CNT_EN
        checks++;
        if (overrun_cnt[15:8] !== 8'd1) begin
            errors++; $display("FAIL cnt_clr_set: got %0d want 1", overrun_cnt[15:8]);
        end
        for (int i = 0; i < 300; i++) begin
            strobe(4'h2, 24'(i));
            tick();
        end
        checks++;
        if (overrun_cnt[15:8] !== 8'd255) begin
            errors++; $display("FAIL cnt_sat: got %0d want 255", overrun_cnt[15:8]);
        end
`endif
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 4'b0000) begin
            errors++; $display("FAIL clr_only: got ov=%b want 0000", overrun);
        end
`ifdef OVERRUN_CNT_EN
        checks++;
        if (overrun_cnt !== 32'd0) begin
            errors++; $display("FAIL cnt_clr: got %h want 0", overrun_cnt);
        end
`endif
        m_ready = 1'b1;
        repeat (6) tick();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL clr_drain: got m_valid=%b want 0", m_valid);
        end
    endtask

    task automatic test_rate_change();
        int low = 0;
        int nb = 0;
        logic [1:0] last_rate = 2'd0;
        logic [25:0] beat = '0;
        m_ready = 1'b0;
        strobe(4'h8, 24'h77 - 24'd3);
        tick();
        rate_sel = 2'd2;
        tick();
        while (!cic_run && low < 100) begin
            low++;
            last_rate = cic_rate;
            checks++;
            if ({m_valid, m_chan, m_data} !== {1'b1, 2'd3, 24'h77}) begin
                errors++;
                $display("FAIL flush_hold: got v=%b ch=%0d d=%h want v=1 ch=3 d=000077",
                         m_valid, m_chan, m_data);
            end
            rx_strobe = (low % 3 == 0) ? 4'hF : 4'h0;
            rx_data = {4{24'hEE}};
            tick();
        end
        rx_strobe = '0;
        checks++;
        if (low != 16 || last_rate !== 2'd2) begin
            errors++; $display("FAIL rate_flush: got low=%0d rate=%0d want 16 2", low, last_rate);
        end
        for (int s = 0; s < 3; s++) begin
            strobe(4'hF, 24'hEE);
            tick();
            checks++;
            if ({m_valid, m_chan, m_data} !== {1'b1, 2'd3, 24'h77}) begin
                errors++;
                $display("FAIL settle_hold: got v=%b ch=%0d d=%h want v=1 ch=3 d=000077",
                         m_valid, m_chan, m_data);
            end
        end
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (m_valid) begin nb++; beat = {m_chan, m_data}; end
            tick();
        end
        checks++;
        if (nb != 1 || beat !== {2'd3, 24'h77}) begin
            errors++; $display("FAIL rate_drain: got beats=%0d last=%h want 1 3000077", nb, beat);
        end
    endtask

    task automatic test_async_reset();
        m_ready = 1'b0;
        strobe(4'hF, 24'h40);
        tick();
        strobe(4'hF, 24'h50);
        tick();
        checks++;
        if (m_valid !== 1'b1 || overrun !== 4'b1110 || cic_run !== 1'b1) begin
            errors++;
            $display("FAIL pre_areset: got v=%b ov=%b run=%b want 1 1110 1", m_valid, overrun, cic_run);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({m_valid, cic_run, overrun, m_data} !== 30'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b run=%b ov=%b d=%h want all zero",
                     m_valid, cic_run, overrun, m_data);
        end
    endtask

    task automatic test_random();
        logic [23:0] mslot [4];
        bit          mfull [4];
        int          mptr = 0;
        bit          mv = 0;
        logic [23:0] md = '0;
        int          mc = 0;
        logic [3:0]  mov = '0;
        int          n = 0;
        tick();
        rate_sel = 2'd0; m_ready = 1'b1; rx_strobe = '0;
        tick();
        reset = 1'b0;
        while (!cic_run && n < 100) begin tick(); n++; end
        checks++;
        if (!cic_run) begin
            errors++; $display("FAIL rand_start: got cic_run=0 want 1 within 100 clocks");
        end
        for (int s = 0; s < 3; s++) begin strobe(4'h1, 24'h0); tick(); end
        for (int k = 0; k < 4; k++) begin mfull[k] = 0; mslot[k] = '0; end
        for (int c = 0; c < 400; c++) begin
            logic [3:0] stb;
            bit ld;
            int g;
            stb = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            m_ready = ($urandom_range(0, 2) != 0);
            overrun_clr = ($urandom_range(0, 40) == 0);
            rx_strobe = stb;
            for (int k = 0; k < 4; k++) rx_data[k*24 +: 24] = 24'($urandom);
            ld = !mv || m_ready;
            g = -1;
            if (ld) begin
                for (int i = 0; i < 4; i++)
                    if (g < 0 && mfull[(mptr + i) % 4]) g = (mptr + i) % 4;
                mv = (g >= 0);
                if (g >= 0) begin
                    md = mslot[g]; mc = g; mfull[g] = 0; mptr = (g + 1) % 4;
                end
            end
            if (overrun_clr) mov = '0;
            for (int k = 0; k < 4; k++) begin
                if (stb[k]) begin
                    if (mfull[k]) mov[k] = 1'b1;
                    mfull[k] = 1;
                    mslot[k] = rx_data[k*24 +: 24];
                end
            end
            tick();
            checks++;
            if (m_valid !== mv || overrun !== mov ||
                (mv && (m_data !== md || m_chan !== 2'(mc)))) begin
                errors++;
                $display("FAIL rand_c%0d: got v=%b ch=%0d d=%h ov=%b want v=%b ch=%0d d=%h ov=%b",
                         c, m_valid, m_chan, m_data, overrun, mv, mc, md, mov);
            end
        end
        rx_strobe = '0; overrun_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_flush_settle();
        test_burst();
        test_overrun();
        test_overrun_clr();
        test_rate_change();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
